// File: rtl/strided_data_lane.sv
// strided_data_lane: address-window/stride filter that compacts SPAD word elements into a replayable circular FIFO.
// Optional packed pops (2/4 elements per pop) are enabled by defining STRIDED_LANE_PACKED_POP_EN.
`default_nettype none

module strided_data_lane #(
  parameter int SPAD_DATA_WIDTH = 64,
  parameter int DATA_WIDTH      = 8,
  parameter int SPAD_N          = SPAD_DATA_WIDTH / DATA_WIDTH,
  parameter int ADDR_WIDTH      = 10,
  parameter int EADDR_WIDTH     = ADDR_WIDTH + $clog2(SPAD_N),
  parameter int FIFO_DEPTH      = 32
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_clear,
  input  logic                       i_cfg_write,
  input  logic [EADDR_WIDTH-1:0]     i_start_addr,
  input  logic [EADDR_WIDTH-1:0]     i_end_addr,
  input  logic [1:0]                 i_stride_log2,
  input  logic                       i_data_valid,
  input  logic [ADDR_WIDTH-1:0]      i_addr,
  input  logic [SPAD_DATA_WIDTH-1:0] i_data,
  output logic                       o_ready,
  input  logic                       i_pop,
  input  logic                       i_rewind,
  input  logic                       i_commit,
  input  logic [1:0]                 i_p_mode,
  output logic [4*DATA_WIDTH-1:0]    o_data,
  output logic                       o_valid,
  output logic                       o_empty,
  output logic                       o_full,
  output logic                       o_route_done
);

  localparam int LOG_N = $clog2(SPAD_N);
  localparam int IDX_W = $clog2(FIFO_DEPTH);
  localparam int PTR_W = IDX_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUTE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t                 state;
  logic                   route_done;
  logic [EADDR_WIDTH-1:0] start_addr;
  logic [EADDR_WIDTH-1:0] end_addr;
  logic [1:0]             stride_log2;
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [PTR_W-1:0]       base_ptr;
  logic [DATA_WIDTH-1:0]  mem [FIFO_DEPTH];

  logic [EADDR_WIDTH-1:0] stride_mask;
  logic [SPAD_N-1:0]      hit;
  logic [PTR_W-1:0]       hit_off [SPAD_N];
  logic [IDX_W-1:0]       wr_idx  [SPAD_N];
  logic [PTR_W-1:0]       hit_cnt;
  logic [PTR_W-1:0]       used;
  logic [PTR_W-1:0]       count;
  logic [PTR_W:0]         free;
  logic [EADDR_WIDTH:0]   word_end;
  logic                   last_word;
  logic                   ready;
  logic                   accept;
  logic [2:0]             pop_n;
  logic                   valid;
  logic                   pop_fire;
  logic [PTR_W-1:0]       rd_next;

  assign stride_mask = EADDR_WIDTH'((4'd1 << stride_log2) - 4'd1);

  generate
    for (genvar k = 0; k < SPAD_N; k++) begin : g_hit
      localparam logic [LOG_N-1:0] K_IDX = LOG_N'(k);
      logic [EADDR_WIDTH-1:0] e_addr;
      logic [EADDR_WIDTH-1:0] e_off;
      logic [PTR_W-1:0]       slot;
      assign e_addr    = EADDR_WIDTH'({i_addr, K_IDX});
      assign e_off     = e_addr - start_addr;
      assign hit[k]    = (e_addr >= start_addr) && (e_addr < end_addr) &&
                         ((e_off & stride_mask) == '0);
      assign slot      = wr_ptr + hit_off[k];
      assign wr_idx[k] = slot[IDX_W-1:0];
    end
  endgenerate

  // Each hit lands at wr plus the number of lower-index hits, keeping element order.
  always_comb begin
    hit_cnt = '0;
    for (int k = 0; k < SPAD_N; k++) begin
      hit_off[k] = hit_cnt;
      hit_cnt    = hit_cnt + PTR_W'(hit[k]);
    end
  end

  assign used      = wr_ptr - base_ptr;
  assign count     = wr_ptr - rd_ptr;
  assign free      = (PTR_W+1)'(FIFO_DEPTH) - {1'b0, used};
  assign ready     = (state == ST_ROUTE) && (free >= (PTR_W+1)'(SPAD_N));
  assign accept    = i_data_valid && ready;
  assign word_end  = (EADDR_WIDTH+1)'({i_addr, {LOG_N{1'b0}}}) + (EADDR_WIDTH+1)'(SPAD_N);
  assign last_word = word_end >= {1'b0, end_addr};

`ifdef STRIDED_LANE_PACKED_POP_EN
  always_comb begin
    case (i_p_mode)
      2'd0:    pop_n = 3'd1;
      2'd1:    pop_n = 3'd2;
      default: pop_n = 3'd4;
    endcase
  end
`else
  logic unused_p_mode;
  assign unused_p_mode = ^i_p_mode;
  assign pop_n         = 3'd1;
`endif

  assign valid    = count >= PTR_W'(pop_n);
  assign pop_fire = i_pop && valid;
  assign rd_next  = rd_ptr + (pop_fire ? PTR_W'(pop_n) : '0);

  always_ff @(posedge i_clk) begin
    if (accept) begin
      for (int k = 0; k < SPAD_N; k++) begin
        if (hit[k]) mem[wr_idx[k]] <= i_data[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= ST_IDLE;
      route_done  <= 1'b0;
      start_addr  <= '0;
      end_addr    <= '0;
      stride_log2 <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      base_ptr    <= '0;
    end else if (i_clear) begin
      state       <= ST_IDLE;
      route_done  <= 1'b0;
      start_addr  <= '0;
      end_addr    <= '0;
      stride_log2 <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      base_ptr    <= '0;
    end else if (i_cfg_write) begin
      state       <= ST_ROUTE;
      route_done  <= 1'b0;
      start_addr  <= i_start_addr;
      end_addr    <= i_end_addr;
      stride_log2 <= i_stride_log2;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      base_ptr    <= '0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + hit_cnt;
        if (last_word) begin
          state      <= ST_DONE;
          route_done <= 1'b1;
        end
      end
      // Rewind overrides pop and commit; commit captures the post-pop read pointer.
      if (i_rewind) begin
        rd_ptr <= base_ptr;
      end else begin
        rd_ptr <= rd_next;
        if (i_commit) base_ptr <= rd_next;
      end
    end
  end

  generate
    for (genvar j = 0; j < 4; j++) begin : g_lane
      logic [PTR_W-1:0] lane_ptr;
      logic             lane_on;
      assign lane_ptr = rd_ptr + PTR_W'(j);
      assign lane_on  = (PTR_W'(j) < PTR_W'(pop_n)) && (PTR_W'(j) < count);
      assign o_data[j*DATA_WIDTH +: DATA_WIDTH] = lane_on ? mem[lane_ptr[IDX_W-1:0]] : '0;
    end
  endgenerate

  assign o_ready      = ready;
  assign o_valid      = valid;
  assign o_empty      = (wr_ptr == rd_ptr);
  assign o_full       = ~(free >= (PTR_W+1)'(SPAD_N));
  assign o_route_done = route_done;

endmodule

`default_nettype wire

// File: tb/tb_strided_data_lane.sv
// tb_strided_data_lane: directed self-checking bench for strided_data_lane (SPAD_N=8, FIFO_DEPTH=32).
`default_nettype none

module tb_strided_data_lane;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_clear = 1'b0;
  logic        i_cfg_write = 1'b0;
  logic [12:0] i_start_addr = '0;
  logic [12:0] i_end_addr = '0;
  logic [1:0]  i_stride_log2 = '0;
  logic        i_data_valid = 1'b0;
  logic [9:0]  i_addr = '0;
  logic [63:0] i_data = '0;
  logic        i_pop = 1'b0;
  logic        i_rewind = 1'b0;
  logic        i_commit = 1'b0;
  logic [1:0]  i_p_mode = 2'd0;
  logic        o_ready;
  logic [31:0] o_data;
  logic        o_valid;
  logic        o_empty;
  logic        o_full;
  logic        o_route_done;

  int checks = 0;
  int failures = 0;

  strided_data_lane dut (
    .i_clk        (clk),
    .i_rst        (i_rst),
    .i_clear      (i_clear),
    .i_cfg_write  (i_cfg_write),
    .i_start_addr (i_start_addr),
    .i_end_addr   (i_end_addr),
    .i_stride_log2(i_stride_log2),
    .i_data_valid (i_data_valid),
    .i_addr       (i_addr),
    .i_data       (i_data),
    .o_ready      (o_ready),
    .i_pop        (i_pop),
    .i_rewind     (i_rewind),
    .i_commit     (i_commit),
    .i_p_mode     (i_p_mode),
    .o_data       (o_data),
    .o_valid      (o_valid),
    .o_empty      (o_empty),
    .o_full       (o_full),
    .o_route_done (o_route_done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input int s, input int e, input int l);
    i_start_addr  = 13'(s);
    i_end_addr    = 13'(e);
    i_stride_log2 = 2'(l);
    i_cfg_write   = 1'b1;
    step();
    i_cfg_write   = 1'b0;
  endtask

  task automatic send_word(input int a);
    i_data_valid = 1'b1;
    i_addr       = 10'(a);
    for (int k = 0; k < 8; k++) i_data[k*8 +: 8] = 8'(a*8 + k);
    step();
    i_data_valid = 1'b0;
  endtask

  task automatic pop_one();
    i_pop = 1'b1;
    step();
    i_pop = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (o_empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", o_empty); end
    checks++; if (o_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", o_ready); end
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", o_valid); end
    checks++; if (o_full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", o_full); end
    checks++; if (o_route_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", o_route_done); end
    checks++; if (o_data !== 32'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", o_data); end
    step();
    i_rst = 1'b0;
    step();
    checks++; if (o_ready !== 1'b0) begin failures++; $display("FAIL idle_ready got=%b exp=0", o_ready); end
  endtask

  task automatic test_contiguous();
    cfg(3, 13, 0);
    checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL contig_ready got=%b exp=1", o_ready); end
    send_word(0);
    checks++; if (o_route_done !== 1'b0) begin failures++; $display("FAIL contig_done_early got=%b exp=0", o_route_done); end
    send_word(1);
    checks++; if (o_route_done !== 1'b1) begin failures++; $display("FAIL contig_done got=%b exp=1", o_route_done); end
    checks++; if (o_ready !== 1'b0) begin failures++; $display("FAIL contig_ready_done got=%b exp=0", o_ready); end
    for (int i = 0; i < 10; i++) begin
      checks++; if (o_valid !== 1'b1) begin failures++; $display("FAIL contig_valid[%0d] got=%b exp=1", i, o_valid); end
      checks++; if (o_data !== 32'(3 + i)) begin failures++; $display("FAIL contig_data[%0d] got=%h exp=%h", i, o_data, 32'(3 + i)); end
      pop_one();
    end
    checks++; if (o_empty !== 1'b1) begin failures++; $display("FAIL contig_empty got=%b exp=1", o_empty); end
    pop_one();
    checks++; if (o_empty !== 1'b1) begin failures++; $display("FAIL contig_pop_empty got=%b exp=1", o_empty); end
  endtask

  task automatic test_stride();
    cfg(2, 16, 1);
    send_word(0);
    send_word(1);
    checks++; if (o_route_done !== 1'b1) begin failures++; $display("FAIL stride_done got=%b exp=1", o_route_done); end
    for (int i = 0; i < 7; i++) begin
      checks++; if (o_data !== 32'(2 + 2*i)) begin failures++; $display("FAIL stride_data[%0d] got=%h exp=%h", i, o_data, 32'(2 + 2*i)); end
      pop_one();
    end
    checks++; if (o_empty !== 1'b1) begin failures++; $display("FAIL stride_empty got=%b exp=1", o_empty); end
  endtask

  task automatic test_full();
    cfg(0, 64, 0);
    for (int w = 0; w < 3; w++) send_word(w);
    checks++; if (o_ready !== 1'b1 || o_full !== 1'b0) begin failures++; $display("FAIL full_24 ready=%b full=%b exp ready=1 full=0", o_ready, o_full); end
    send_word(3);
    checks++; if (o_ready !== 1'b0 || o_full !== 1'b1) begin failures++; $display("FAIL full_32 ready=%b full=%b exp ready=0 full=1", o_ready, o_full); end
    send_word(4);
    for (int i = 0; i < 8; i++) begin
      checks++; if (o_data !== 32'(i)) begin failures++; $display("FAIL full_pop[%0d] got=%h exp=%h", i, o_data, 32'(i)); end
      pop_one();
    end
    checks++; if (o_ready !== 1'b0) begin failures++; $display("FAIL full_uncommitted got=%b exp=0", o_ready); end
    i_commit = 1'b1; step(); i_commit = 1'b0;
    checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL full_commit_ready got=%b exp=1", o_ready); end
    send_word(4);
    checks++; if (o_route_done !== 1'b0) begin failures++; $display("FAIL full_not_done got=%b exp=0", o_route_done); end
    for (int i = 0; i < 32; i++) begin
      checks++; if (o_data !== 32'(8 + i)) begin failures++; $display("FAIL full_drain[%0d] got=%h exp=%h", i, o_data, 32'(8 + i)); end
      pop_one();
    end
    checks++; if (o_empty !== 1'b1) begin failures++; $display("FAIL full_empty got=%b exp=1", o_empty); end
  endtask

  task automatic test_rewind();
    cfg(3, 13, 0);
    send_word(0);
    send_word(1);
    for (int i = 0; i < 4; i++) pop_one();
    checks++; if (o_data !== 32'd7) begin failures++; $display("FAIL rew_after_pop got=%h exp=7", o_data); end
    i_rewind = 1'b1; step(); i_rewind = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (o_data !== 32'(3 + i)) begin failures++; $display("FAIL rew_replay[%0d] got=%h exp=%h", i, o_data, 32'(3 + i)); end
      pop_one();
    end
    i_commit = 1'b1; step(); i_commit = 1'b0;
    i_rewind = 1'b1; step(); i_rewind = 1'b0;
    checks++; if (o_data !== 32'd7) begin failures++; $display("FAIL rew_committed got=%h exp=7", o_data); end
    pop_one();
    checks++; if (o_data !== 32'd8) begin failures++; $display("FAIL rew_pop8 got=%h exp=8", o_data); end
    i_commit = 1'b1; i_rewind = 1'b1; step(); i_commit = 1'b0; i_rewind = 1'b0;
    checks++; if (o_data !== 32'd7) begin failures++; $display("FAIL rew_beats_commit got=%h exp=7", o_data); end
    i_pop = 1'b1; i_rewind = 1'b1; step(); i_pop = 1'b0; i_rewind = 1'b0;
    checks++; if (o_data !== 32'd7) begin failures++; $display("FAIL rew_beats_pop got=%h exp=7", o_data); end
  endtask

  task automatic test_clear();
    cfg(3, 13, 0);
    send_word(0);
    checks++; if (o_valid !== 1'b1) begin failures++; $display("FAIL clr_pre_valid got=%b exp=1", o_valid); end
    i_clear = 1'b1; step(); i_clear = 1'b0;
    checks++; if (o_empty !== 1'b1 || o_ready !== 1'b0 || o_route_done !== 1'b0 || o_valid !== 1'b0)
      begin failures++; $display("FAIL clr_state empty=%b ready=%b done=%b valid=%b exp 1 0 0 0", o_empty, o_ready, o_route_done, o_valid); end
    send_word(1);
    checks++; if (o_empty !== 1'b1) begin failures++; $display("FAIL clr_ignored got=%b exp=1", o_empty); end
    i_clear = 1'b1;
    cfg(3, 13, 0);
    i_clear = 1'b0;
    checks++; if (o_ready !== 1'b0) begin failures++; $display("FAIL clr_beats_cfg got=%b exp=0", o_ready); end
    cfg(3, 13, 0);
    checks++; if (o_ready !== 1'b1 || o_empty !== 1'b1) begin failures++; $display("FAIL clr_recfg ready=%b empty=%b exp 1 1", o_ready, o_empty); end
    send_word(0);
    #2 i_rst = 1'b1;
    #1;
    checks++; if (o_empty !== 1'b1 || o_ready !== 1'b0) begin failures++; $display("FAIL async_rst empty=%b ready=%b exp 1 0", o_empty, o_ready); end
    step();
    i_rst = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    cfg(0, 64, 0);
    send_word(0);
    checks++; if (o_data !== 32'd0) begin failures++; $display("FAIL b2b_head got=%h exp=0", o_data); end
    i_pop = 1'b1;
    send_word(1);
    i_pop = 1'b0;
    for (int i = 0; i < 15; i++) begin
      checks++; if (o_data !== 32'(1 + i)) begin failures++; $display("FAIL b2b_data[%0d] got=%h exp=%h", i, o_data, 32'(1 + i)); end
      pop_one();
    end
    checks++; if (o_empty !== 1'b1) begin failures++; $display("FAIL b2b_empty got=%b exp=1", o_empty); end
  endtask

`ifdef STRIDED_LANE_PACKED_POP_EN
  task automatic test_packed_pop();
    cfg(3, 13, 0);
    send_word(0);
    send_word(1);
    i_p_mode = 2'd2;
    checks++; if (o_valid !== 1'b1 || o_data !== 32'h06050403) begin failures++; $display("FAIL pk_first valid=%b data=%h exp 1 06050403", o_valid, o_data); end
    pop_one();
    checks++; if (o_data !== 32'h0a090807) begin failures++; $display("FAIL pk_second got=%h exp=0a090807", o_data); end
    pop_one();
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL pk_short got=%b exp=0", o_valid); end
    pop_one();
    i_p_mode = 2'd1;
    checks++; if (o_valid !== 1'b1 || o_data !== 32'h00000c0b) begin failures++; $display("FAIL pk_pair valid=%b data=%h exp 1 00000c0b", o_valid, o_data); end
    pop_one();
    i_p_mode = 2'd0;
    checks++; if (o_empty !== 1'b1) begin failures++; $display("FAIL pk_empty got=%b exp=1", o_empty); end
  endtask
`endif

  initial begin
    test_reset();
    test_contiguous();
    test_stride();
    test_full();
    test_rewind();
    test_clear();
    test_back_to_back();
`ifdef STRIDED_LANE_PACKED_POP_EN
    test_packed_pop();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/strided_data_lane.md
Name: strided_data_lane

Overview:
Next-generation row/column data lane for the router. Captures an element address window and a power-of-two stride. Filters SPAD words from the tile reader and compacts the hit elements, in order, into an internal circular FIFO. Replaces the external MISO FIFO and adds rewind/commit replay so the PE array can reuse a tile without re-reading SPAD.

Parameters:
SPAD_DATA_WIDTH, 64, SPAD word width in bits
DATA_WIDTH, 8, element width in bits
SPAD_N, SPAD_DATA_WIDTH/DATA_WIDTH, elements per SPAD word (power of two)
ADDR_WIDTH, 10, SPAD word address width
EADDR_WIDTH, ADDR_WIDTH+$clog2(SPAD_N), element address width
FIFO_DEPTH, 32, FIFO entries (power of two, >= 2*SPAD_N)

Ports:
i_clk  in  1  clock
i_rst  in  1  asynchronous active-high reset
i_clear  in  1  synchronous clear to IDLE
i_cfg_write  in  1  load window/stride, start routing
i_start_addr  in  EADDR_WIDTH  first element address (inclusive)
i_end_addr  in  EADDR_WIDTH  last element address (exclusive)
i_stride_log2  in  2  stride = 1<<i_stride_log2
i_data_valid  in  1  SPAD word present
i_addr  in  ADDR_WIDTH  SPAD word address
i_data  in  SPAD_DATA_WIDTH  element k at [k*DATA_WIDTH +: DATA_WIDTH]
o_ready  out  1  word accepted this cycle if i_data_valid
i_pop  in  1  consume head element(s)
i_rewind  in  1  read pointer back to committed base
i_commit  in  1  free consumed entries
i_p_mode  in  2  pop packing (optional feature)
o_data  out  4*DATA_WIDTH  head element(s), show-ahead
o_valid  out  1  enough readable entries for one pop
o_empty  out  1  no readable entries
o_full  out  1  free slots < SPAD_N
o_route_done  out  1  state == DONE

Behaviour:
- Reset/clear: state IDLE; wr/rd/base pointers (log2(FIFO_DEPTH)+1 bits) = 0; window regs = 0; all outputs 0 except o_empty=1.
- FSM states:
  - IDLE --i_cfg_write--> ROUTE.
  - ROUTE --accepted word with i_addr*SPAD_N+SPAD_N >= end--> DONE.
  - DONE --i_cfg_write--> ROUTE.
  - i_clear from any state --> IDLE; i_clear beats i_cfg_write.
- i_cfg_write in any state: latch window/stride; pointers to 0; FIFO contents discarded.
- Element address e_k = i_addr*SPAD_N + k, computed in EADDR_WIDTH bits (no truncation).
- Hit_k = (e_k >= start) && (e_k < end) && ((e_k - start) & (stride-1)) == 0.
- o_ready = (state==ROUTE) && free >= SPAD_N, where free = FIFO_DEPTH - (wr - base).
- Accept = i_data_valid && o_ready:
  - Hit elements are written lowest-k first into consecutive slots from wr.
  - wr += popcount(hit); zero hits still consumes the word.
- Data written in cycle N is visible on o_data/o_valid in cycle N+1.
- i_data_valid in IDLE/DONE or with o_ready=0: ignored, no side effect.
- Pop: when i_pop && o_valid, rd += n (n = 1 without the optional feature). i_pop with o_valid=0 is ignored.
- o_data = entries at rd.., combinational from FIFO storage.
- Priority: i_rewind (rd <= base; pop and commit ignored) > i_commit (base <= rd after same-cycle pop) > pop.
- Simultaneous accept and pop both take effect. free is evaluated on pre-cycle base.
- Pointer wrap is modulo FIFO_DEPTH; the extra MSB distinguishes full from empty.
- o_empty = (wr == rd); o_full = ~(free >= SPAD_N).
- Replay: entries between base and wr survive pops until commit, so repeated rewind replays identical data.
- Reset mid-route: immediate return to IDLE, data lost.

Optional Feature:
- Macro STRIDED_LANE_PACKED_POP_EN.
- When defined, i_p_mode selects n per pop: 0→1, 1→2, 2→4, 3→4 elements.
  - o_data lane j = entry rd+j for j < n; lanes j >= n are 0.
  - o_valid = (wr - rd) >= n.
- Undefined: n=1, i_p_mode ignored, o_data[4*DATA_WIDTH-1:DATA_WIDTH] tied 0.

Test Plan:
- SPAD_N=8, cfg start=3 end=13 stride_log2=0; word addr0 bytes 0..7, addr1 bytes 8..15 -> 10 entries 3..12 pop in order; o_route_done=1 cycle after addr1 accepted.
- cfg start=2 end=16 stride_log2=1, same two words -> entries 2,4,6,8,10,12,14 only; o_empty after 7 pops.
- FIFO_DEPTH=32, window 0..64 stride 1, no pops -> o_ready drops after 4 words (free=0); pop 8 + commit -> o_ready=1, next word accepted.
- After 10 entries: pop 4, rewind -> o_data=first entry again, same 4 values re-popped; then commit + rewind -> rd unchanged.
- i_clear asserted while ROUTE with 5 entries -> next cycle o_empty=1, o_ready=0, o_route_done=0; i_data_valid ignored until cfg.
- With STRIDED_LANE_PACKED_POP_EN, i_p_mode=2, entries 3..12 -> pops yield {3,4,5,6},{7,8,9,10}; o_valid=0 with 2 left; i_p_mode=1 pops {11,12}.
